// File: rtl/dffram_bist.sv
// March C- subset BIST for a 32-bit wide DFFRAM of 256*WSIZE words.
// Every RAM-facing and status output comes straight from a flop.
module dffram_bist #(
    parameter int unsigned WSIZE = 4,
    parameter logic [31:0] PATTERN = 32'h00000000,
    localparam int unsigned A_WIDTH = 8 + $clog2(WSIZE),
    localparam int unsigned N = 256 * WSIZE
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [31:0]        fail_data,
    output logic               ram_EN,
    output logic [3:0]         ram_WE,
    output logic [A_WIDTH-1:0] ram_A,
    output logic [31:0]        ram_Di,
    input  logic [31:0]        ram_Do
);

    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(N - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        R0W1 = 3'd2,
        R1W0 = 3'd3,
        RF   = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [A_WIDTH-1:0] addr, addr_n;
    logic               ph, ph_n;
    logic               rd_pend, rd_pend_n;
    logic [A_WIDTH-1:0] rd_addr, rd_addr_n;
    logic [31:0]        rd_exp, rd_exp_n;

    logic               busy_n, done_n, fail_n;
    logic [A_WIDTH-1:0] fail_addr_n;
    logic [31:0]        fail_data_n;
    logic               en_n;
    logic [3:0]         we_n;
    logic [A_WIDTH-1:0] a_n;
    logic [31:0]        di_n;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            addr      <= '0;
            ph        <= 1'b0;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
            rd_exp    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            ram_EN    <= 1'b0;
            ram_WE    <= 4'h0;
            ram_A     <= '0;
            ram_Di    <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            ph        <= ph_n;
            rd_pend   <= rd_pend_n;
            rd_addr   <= rd_addr_n;
            rd_exp    <= rd_exp_n;
            busy      <= busy_n;
            done      <= done_n;
            fail      <= fail_n;
            fail_addr <= fail_addr_n;
            fail_data <= fail_data_n;
            ram_EN    <= en_n;
            ram_WE    <= we_n;
            ram_A     <= a_n;
            ram_Di    <= di_n;
        end
    end

    // Next state, sequencing and registered-output values
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        ph_n        = ph;
        done_n      = done;
        fail_n      = fail;
        fail_addr_n = fail_addr;
        fail_data_n = fail_data;
        en_n        = 1'b0;
        we_n        = 4'h0;
        a_n         = '0;
        di_n        = '0;

        // A read issued this cycle is compared against ram_Do next cycle
        rd_pend_n = ram_EN && (ram_WE == 4'h0);
        rd_addr_n = ram_A;
        rd_exp_n  = (state == R1W0) ? ~PATTERN : PATTERN;

        if (rd_pend && (ram_Do != rd_exp) && !fail) begin
            fail_n      = 1'b1;
            fail_addr_n = rd_addr;
            fail_data_n = ram_Do;
        end

        case (state)
            IDLE, FIN: begin
                if (start) begin
                    state_n     = W0;
                    addr_n      = '0;
                    ph_n        = 1'b0;
                    done_n      = 1'b0;
                    fail_n      = 1'b0;
                    fail_addr_n = '0;
                    fail_data_n = '0;
                end
            end
            W0: begin
                if (addr == LAST) begin
                    state_n = R0W1;
                    addr_n  = '0;
                end else begin
                    addr_n = addr + A_WIDTH'(1);
                end
            end
            R0W1: begin
                ph_n = !ph;
                if (ph) begin
                    if (addr == LAST) begin
                        state_n = R1W0;
                        addr_n  = LAST;
                    end else begin
                        addr_n = addr + A_WIDTH'(1);
                    end
                end
            end
            R1W0: begin
                ph_n = !ph;
                if (ph) begin
                    if (addr == '0) begin
                        state_n = RF;
                    end else begin
                        addr_n = addr - A_WIDTH'(1);
                    end
                end
            end
            RF: begin
                // ph marks the drain cycle that lets the last read be compared
                if (ph) begin
                    state_n = FIN;
                    ph_n    = 1'b0;
                    done_n  = 1'b1;
                end else if (addr == LAST) begin
                    ph_n = 1'b1;
                end else begin
                    addr_n = addr + A_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            W0: begin
                en_n = 1'b1;
                we_n = 4'hF;
                a_n  = addr_n;
                di_n = PATTERN;
            end
            R0W1: begin
                en_n = 1'b1;
                we_n = ph_n ? 4'hF : 4'h0;
                a_n  = addr_n;
                di_n = ~PATTERN;
            end
            R1W0: begin
                en_n = 1'b1;
                we_n = ph_n ? 4'hF : 4'h0;
                a_n  = addr_n;
                di_n = PATTERN;
            end
            RF: begin
                en_n = !ph_n;
                a_n  = addr_n;
            end
            default: ;
        endcase

        busy_n = (state_n != IDLE) && (state_n != FIN);
    end

endmodule
